// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
// Requester count, select width, FSM state encoding and a one-hot decoder.
package rr_arb_pkg;
   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] sel);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[sel] = 1'b1;
      return v;
   endfunction
endpackage

// File: rtl/mux4x1.sv
// Plain 4:1 one-bit multiplexer; S picks which I bit drives Y.
module mux4x1 (
   input  logic [3:0] I,
   input  logic [1:0] S,
   output logic       Y
);
   assign Y = I[S];
endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set bit of req, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
// Purely combinational; win is don't-care when any is low.
module rr_pick4
   import rr_arb_pkg::*;
(
   input  logic [SEL_W-1:0]   ptr,
   input  logic [NUM_REQ-1:0] req,
   output logic [SEL_W-1:0]   win,
   output logic               any
);
   logic [SEL_W-1:0]   idx [NUM_REQ];
   logic [NUM_REQ-1:0] hit;

   // hit[gi] is the request seen at search position gi, counted from ptr
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign idx[gi] = ptr + SEL_W'(gi);
      assign hit[gi] = req[idx[gi]];
   end

   always_comb begin
      win = ptr;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (hit[i]) win = idx[i];
      end
   end

   assign any = |hit;
endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter owning the select of a 4:1 one-bit mux, with valid/ready output
// and a cap of HOLD_MAX transfers per grant before priority rotates.
module rr_mux4_arbiter
   import rr_arb_pkg::*;
#(
   parameter int HOLD_MAX = 4,
   parameter int CNT_W    = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] data,
   input  logic               out_ready,
   output logic [NUM_REQ-1:0] gnt,
   output logic [SEL_W-1:0]   sel,
   output logic               out_valid,
   output logic               y,
   output logic               busy
);
   state_t             state_reg;
   logic [NUM_REQ-1:0] gnt_reg;
   logic [SEL_W-1:0]   sel_reg;
   logic [SEL_W-1:0]   ptr_reg;
   logic [CNT_W-1:0]   cnt_reg;

   logic [SEL_W-1:0]   idle_win, rel_win, rel_ptr;
   logic               idle_any, rel_any;
   logic [NUM_REQ-1:0] rel_req;
   logic               transfer, last_xfer, release_now, mux_y;

   // On release the current owner is masked so it cannot win back-to-back
   assign rel_ptr = sel_reg + SEL_W'(1);
   assign rel_req = req & ~onehot4(sel_reg);

   rr_pick4 u_pick_idle (
      .ptr (ptr_reg),
      .req (req),
      .win (idle_win),
      .any (idle_any)
   );

   rr_pick4 u_pick_rel (
      .ptr (rel_ptr),
      .req (rel_req),
      .win (rel_win),
      .any (rel_any)
   );

   assign busy        = (state_reg == GRANT);
   assign out_valid   = busy && req[sel_reg];
   assign transfer    = out_valid && out_ready;
   assign last_xfer   = transfer && (cnt_reg == CNT_W'(HOLD_MAX - 1));
   assign release_now = !req[sel_reg] || last_xfer;

   mux4x1 u_mux (
      .I (data),
      .S (sel_reg),
      .Y (mux_y)
   );

   assign y   = mux_y & out_valid;
   assign gnt = gnt_reg;
   assign sel = sel_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         gnt_reg   <= '0;
         sel_reg   <= '0;
         ptr_reg   <= '0;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (idle_any) begin
                  state_reg <= GRANT;
                  gnt_reg   <= onehot4(idle_win);
                  sel_reg   <= idle_win;
                  cnt_reg   <= '0;
               end
            end
            GRANT: begin
               if (release_now) begin
                  ptr_reg <= rel_ptr;
                  if (rel_any) begin
                     gnt_reg <= onehot4(rel_win);
                     sel_reg <= rel_win;
                     cnt_reg <= '0;
                  end else begin
                     // sel keeps its last value while idle
                     gnt_reg   <= '0;
                     state_reg <= IDLE;
                  end
               end else if (transfer) begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            default: begin
               state_reg <= IDLE;
               gnt_reg   <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter: reset, rotation, backpressure, early drop,
// skip/wrap and mid-grant reset, each with hand-computed expectations.
module tb_rr_mux4_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] data;
   logic       out_ready;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       out_valid;
   logic       y;
   logic       busy;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   rr_mux4_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .data      (data),
      .out_ready (out_ready),
      .gnt       (gnt),
      .sel       (sel),
      .out_valid (out_valid),
      .y         (y),
      .busy      (busy)
   );

   // advance one rising edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = 4'b0000; data = 4'b0000; out_ready = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 4'b1111; data = 4'b1111; out_ready = 1'b1;
      tick();
      tick();
      tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      tests_run++; if (sel !== 2'd0) begin tests_failed++; $display("FAIL reset_sel: got %0d want 0", sel); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      tests_run++; if (y !== 1'b0) begin tests_failed++; $display("FAIL reset_y: got %b want 0", y); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst_n = 1'b1;
      tick();
      tests_run++; if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL reset_first_gnt: got %b want 0001", gnt); end
      tests_run++; if (sel !== 2'd0) begin tests_failed++; $display("FAIL reset_first_sel: got %0d want 0", sel); end
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL reset_first_busy: got %b want 1", busy); end
      $display("[TB] reset: gnt=%b sel=%0d busy=%b", gnt, sel, busy);
   endtask

   task automatic test_rotation();
      logic [1:0] exp_sel;
      logic [3:0] exp_gnt;
      logic       exp_y;
      do_reset();
      req = 4'b1111; data = 4'b1010; out_ready = 1'b1;
      tick();
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < 4; c++) begin
            exp_sel = 2'(g % 4);
            exp_gnt = 4'b0001 << exp_sel;
            exp_y   = data[exp_sel];
            tests_run++; if (sel !== exp_sel) begin tests_failed++; $display("FAIL rot_sel g%0d c%0d: got %0d want %0d", g, c, sel, exp_sel); end
            tests_run++; if (gnt !== exp_gnt) begin tests_failed++; $display("FAIL rot_gnt g%0d c%0d: got %b want %b", g, c, gnt, exp_gnt); end
            tests_run++; if (y !== exp_y) begin tests_failed++; $display("FAIL rot_y g%0d c%0d: got %b want %b", g, c, y, exp_y); end
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rot_valid g%0d c%0d: got %b want 1", g, c, out_valid); end
            $display("[TB] rotation xfer: sel=%0d gnt=%b y=%b", sel, gnt, y);
            tick();
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      req = 4'b0100; data = 4'b0100; out_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         tests_run++; if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL bp_stall_gnt %0d: got %b want 0100", i, gnt); end
         tests_run++; if (y !== 1'b1) begin tests_failed++; $display("FAIL bp_stall_y %0d: got %b want 1", i, y); end
         $display("[TB] backpressure stall: gnt=%b valid=%b", gnt, out_valid);
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests_run++; if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL bp_xfer_gnt %0d: got %b want 0100", i, gnt); end
         $display("[TB] backpressure xfer: gnt=%b y=%b", gnt, y);
         tick();
      end
      tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL bp_idle_gnt: got %b want 0000", gnt); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_idle_busy: got %b want 0", busy); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_idle_valid: got %b want 0", out_valid); end
      tests_run++; if (sel !== 2'd2) begin tests_failed++; $display("FAIL bp_idle_sel: got %0d want 2", sel); end
      tick();
      tests_run++; if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL bp_regrant_gnt: got %b want 0100", gnt); end
      tests_run++; if (sel !== 2'd2) begin tests_failed++; $display("FAIL bp_regrant_sel: got %0d want 2", sel); end
      $display("[TB] backpressure regrant: gnt=%b sel=%0d", gnt, sel);
   endtask

   task automatic test_early_drop();
      do_reset();
      req = 4'b0010; data = 4'b1000; out_ready = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         tests_run++; if (sel !== 2'd1) begin tests_failed++; $display("FAIL drop_sel1 %0d: got %0d want 1", i, sel); end
         tick();
      end
      req = 4'b1000;
      #1;
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL drop_valid: got %b want 0", out_valid); end
      tick();
      // new owner must get a fresh budget of four transfers
      for (int i = 0; i < 4; i++) begin
         tests_run++; if (sel !== 2'd3) begin tests_failed++; $display("FAIL drop_sel3 %0d: got %0d want 3", i, sel); end
         tests_run++; if (gnt !== 4'b1000) begin tests_failed++; $display("FAIL drop_gnt3 %0d: got %b want 1000", i, gnt); end
         tests_run++; if (y !== 1'b1) begin tests_failed++; $display("FAIL drop_y3 %0d: got %b want 1", i, y); end
         $display("[TB] early drop xfer: sel=%0d y=%b", sel, y);
         tick();
      end
      tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL drop_end_gnt: got %b want 0000", gnt); end
   endtask

   task automatic test_skip_wrap();
      do_reset();
      req = 4'b0100; data = 4'b0001; out_ready = 1'b1;
      tick();
      req = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         tests_run++; if (sel !== 2'd2) begin tests_failed++; $display("FAIL wrap_sel2 %0d: got %0d want 2", i, sel); end
         tests_run++; if (y !== 1'b0) begin tests_failed++; $display("FAIL wrap_y2 %0d: got %b want 0", i, y); end
         tick();
      end
      tests_run++; if (sel !== 2'd0) begin tests_failed++; $display("FAIL wrap_sel0: got %0d want 0", sel); end
      tests_run++; if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL wrap_gnt0: got %b want 0001", gnt); end
      tests_run++; if (y !== 1'b1) begin tests_failed++; $display("FAIL wrap_y0: got %b want 1", y); end
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL wrap_busy: got %b want 1", busy); end
      $display("[TB] skip/wrap: sel=%0d gnt=%b y=%b", sel, gnt, y);
   endtask

   task automatic test_mid_reset();
      do_reset();
      req = 4'b1111; data = 4'b0000; out_ready = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) tick();
      tests_run++; if (sel !== 2'd1) begin tests_failed++; $display("FAIL midrst_pre_sel: got %0d want 1", sel); end
      tick();
      rst_n = 1'b0;
      tick();
      tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL midrst_gnt: got %b want 0000", gnt); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b want 0", busy); end
      tests_run++; if (sel !== 2'd0) begin tests_failed++; $display("FAIL midrst_sel: got %0d want 0", sel); end
      rst_n = 1'b1;
      tick();
      tests_run++; if (sel !== 2'd0) begin tests_failed++; $display("FAIL midrst_regrant_sel: got %0d want 0", sel); end
      tests_run++; if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL midrst_regrant_gnt: got %b want 0001", gnt); end
      $display("[TB] mid reset regrant: sel=%0d gnt=%b", sel, gnt);
   endtask

   initial begin
      rst_n = 1'b0; req = 4'b0000; data = 4'b0000; out_ready = 1'b0;
      test_reset();
      test_rotation();
      test_backpressure();
      test_early_drop();
      test_skip_wrap();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
